// File: rtl/vram_pkg.sv
// Shared encodings for the VRAM slot arbiter: owner codes, window phase numbers and
// the slot counter reset value.
package vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStrobe  = 2'd1,
    StLatch   = 2'd2,
    StRelease = 2'd3
  } acc_state_e;

  localparam logic [1:0] PH_ADDR    = 2'd0;
  localparam logic [1:0] PH_STROBE  = 2'd1;
  localparam logic [1:0] PH_LATCH   = 2'd2;
  localparam logic [1:0] PH_RELEASE = 2'd3;

  // Same load value as the system clock divider so both stay in step after reset.
  localparam logic [2:0] SLOT_RESET = 3'b100;

endpackage

// File: rtl/slot_phase_ctr.sv
// Free-running 3-bit slot phase counter on the falling edge of CLK_24M,
// asynchronously loaded with SLOT_RESET.
module slot_phase_ctr
  import vram_pkg::*;
(
  input  logic       CLK_24M,
  input  logic       nRESETP,
  output logic [2:0] phase
);

  logic [2:0] phase_q;

  always_ff @(negedge CLK_24M or negedge nRESETP) begin
    if (!nRESETP) begin
      phase_q <= SLOT_RESET;
    end else begin
      phase_q <= phase_q + 3'd1;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one VRAM port between video fetch (phases 0-3) and the
// 68k CPU (phases 4-7); one complete access per 4-phase window.
module vram_slot_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 16,
  parameter bit          ALLOW_STEAL = 1'b1
) (
  input  logic              CLK_24M,
  input  logic              nRESETP,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic              VID_ACK,
  output logic [DATA_W-1:0] VID_RDATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              nMEM_OE,
  output logic              nMEM_WE,
  output logic [2:0]        SLOT_PHASE
);

  logic [2:0] phase;

  slot_phase_ctr u_phase_ctr (
    .CLK_24M (CLK_24M),
    .nRESETP (nRESETP),
    .phase   (phase)
  );

  acc_state_e        state_q, state_d;
  owner_e            owner_q, owner_d, grant;
  logic              we_q, we_d, grant_we;
  logic              noe_q, noe_d, nwe_q, nwe_d;
  logic              vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d;

  // Grant is only evaluated at the first phase of a window; phase[2] selects the window.
  always_comb begin
    grant = OWN_NONE;
    if (phase[1:0] == PH_ADDR) begin
      if (!phase[2]) begin
        if (VID_REQ) begin
          grant = OWN_VID;
        end else if (CPU_REQ && ALLOW_STEAL) begin
          grant = OWN_CPU;
        end
      end else if (CPU_REQ) begin
        grant = OWN_CPU;
      end
    end
    grant_we = (grant == OWN_CPU) && CPU_WE;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    noe_d       = noe_q;
    nwe_d       = nwe_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant != OWN_NONE) begin
          state_d = StStrobe;
          owner_d = grant;
          we_d    = grant_we;
          noe_d   = grant_we;
          nwe_d   = !grant_we;
          if (grant == OWN_VID) begin
            addr_d = VID_ADDR;
          end else begin
            addr_d  = CPU_ADDR;
            wdata_d = CPU_WDATA;
          end
        end
      end
      StStrobe: state_d = StLatch;
      StLatch: begin
        state_d = StRelease;
        noe_d   = 1'b1;
        nwe_d   = 1'b1;
        if (owner_q == OWN_VID) begin
          vid_ack_d   = 1'b1;
          vid_rdata_d = MEM_RDATA;
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = MEM_RDATA;
        end
      end
      StRelease: begin
        state_d = StIdle;
        owner_d = OWN_NONE;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge CLK_24M or negedge nRESETP) begin
    if (!nRESETP) begin
      state_q     <= StIdle;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      noe_q       <= noe_d;
      nwe_q       <= nwe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign VID_ACK    = vid_ack_q;
  assign VID_RDATA  = vid_rdata_q;
  assign CPU_ACK    = cpu_ack_q;
  assign CPU_RDATA  = cpu_rdata_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = wdata_q;
  assign nMEM_OE    = noe_q;
  assign nMEM_WE    = nwe_q;
  assign SLOT_PHASE = phase;

endmodule
